// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer driving system reset from a stable PLL lock
module pll_lock_sequencer #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clock_in,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_resetb,
    output logic       sys_resetn,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] RESET_LAST   = CW'(PLL_RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          pll_resetb_q, pll_resetb_d;
    logic          sys_resetn_q, sys_resetn_d;
    logic          fault_q, fault_d;
    logic          sync1_q, lock_s_q;
    logic          restart;
    logic          take_retry;

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        restart    = 1'b0;
        take_retry = 1'b0;

        if (soft_reset_req) begin
            // Restart even if already in PLL_RESET, so the RESETB pulse is full length.
            restart = 1'b1;
            state_d = ST_PLL_RESET;
            if (state_q == ST_FAULT) begin
                retry_d = 4'd0;
            end
        end else begin
            case (state_q)
                ST_PLL_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        take_retry = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s_q) begin
                        take_retry = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_d = ST_PLL_RESET;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_PLL_RESET;
            endcase

            if (take_retry) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_PLL_RESET;
                    retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                end
            end
        end

        // Counter only runs in timed states; held in RUN/FAULT so it never wraps.
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        pll_resetb_d = !((state_d == ST_PLL_RESET) || (state_d == ST_FAULT));
        sys_resetn_d = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_PLL_RESET;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            fault_q      <= 1'b0;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_resetb_q <= pll_resetb_d;
            sys_resetn_q <= sys_resetn_d;
            fault_q      <= fault_d;
            sync1_q      <= pll_locked;
            lock_s_q     <= sync1_q;
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign sys_resetn  = sys_resetn_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_resetb;
    logic       sys_resetn;
    logic       fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    pll_lock_sequencer #(
        .PLL_RESET_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .STABLE_CYCLES       (8),
        .MAX_RETRIES         (2)
    ) dut (
        .clock_in       (clk),
        .resetn         (resetn),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_resetb     (pll_resetb),
        .sys_resetn     (sys_resetn),
        .fault          (fault),
        .retry_count    (retry_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output bundle {state, pll_resetb, sys_resetn, fault, retry_count}; cyc=-1 means "at async reset".
    typedef struct {
        int         cyc;
        logic [9:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   b, b2, b3;

    function automatic logic [9:0] pk(input int st, input int prb, input int srn, input int flt, input int rc);
        return {st[2:0], prb[0], srn[0], flt[0], rc[3:0]};
    endfunction

    task automatic expect_at(input int c, input logic [9:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: clock falling edge checks due entries; reset falling edge (clk high) checks async entries.
    always begin
        @(negedge clk or negedge resetn);
        if (clk) begin
            #1;
            while (q.size() > 0 && q[0].cyc == -1) begin
                exp_t e;
                logic [9:0] act;
                e   = q.pop_front();
                act = {state, pll_resetb, sys_resetn, fault, retry_count};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL async_reset: got %b expected %b", act, e.v);
                end
            end
        end else begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                logic [9:0] act;
                e   = q.pop_front();
                act = {state, pll_resetb, sys_resetn, fault, retry_count};
                total++;
                if (e.cyc != cyc) begin
                    bad++;
                    $display("FAIL stale_entry cyc%0d: never checked, now at cyc %0d expected %b", e.cyc, cyc, e.v);
                end else if (act !== e.v) begin
                    bad++;
                    $display("FAIL cyc%0d: got st/prb/srn/flt/rc=%b expected %b", cyc, act, e.v);
                end
            end
        end
    end

    initial begin
        expect_at(2, pk(0, 0, 0, 0, 0));
        step_to(3);

        // Nominal start, lock loss in RUN, soft reset in RUN, STABLE glitch.
        b = cyc;
        expect_at(b + 3,  pk(0, 0, 0, 0, 0));
        expect_at(b + 4,  pk(1, 1, 0, 0, 0));
        expect_at(b + 11, pk(1, 1, 0, 0, 0));
        expect_at(b + 12, pk(2, 1, 0, 0, 0));
        expect_at(b + 19, pk(2, 1, 0, 0, 0));
        expect_at(b + 20, pk(3, 1, 1, 0, 0));
        expect_at(b + 26, pk(3, 1, 1, 0, 0));
        expect_at(b + 27, pk(0, 0, 0, 0, 0));
        expect_at(b + 31, pk(1, 1, 0, 0, 0));
        expect_at(b + 34, pk(1, 1, 0, 0, 0));
        expect_at(b + 35, pk(2, 1, 0, 0, 0));
        expect_at(b + 42, pk(2, 1, 0, 0, 0));
        expect_at(b + 43, pk(3, 1, 1, 0, 0));
        expect_at(b + 46, pk(0, 0, 0, 0, 0));
        expect_at(b + 50, pk(1, 1, 0, 0, 0));
        expect_at(b + 51, pk(2, 1, 0, 0, 0));
        expect_at(b + 59, pk(3, 1, 1, 0, 0));
        expect_at(b + 62, pk(0, 0, 0, 0, 0));
        expect_at(b + 67, pk(2, 1, 0, 0, 0));
        expect_at(b + 72, pk(2, 1, 0, 0, 0));
        expect_at(b + 73, pk(0, 0, 0, 0, 1));
        expect_at(b + 77, pk(1, 1, 0, 0, 1));
        expect_at(b + 78, pk(2, 1, 0, 0, 1));
        expect_at(b + 86, pk(3, 1, 1, 0, 0));
        expect_at(b + 89, pk(0, 0, 0, 0, 0));
        expect_at(b + 94, pk(2, 1, 0, 0, 0));
        resetn = 1'b1;

        step_to(b + 9);  pll_locked = 1'b1;
        step_to(b + 24); pll_locked = 1'b0;
        step_to(b + 32); pll_locked = 1'b1;
        step_to(b + 45); soft_reset_req = 1'b1;
        step_to(b + 46); soft_reset_req = 1'b0;
        step_to(b + 61); soft_reset_req = 1'b1;
        step_to(b + 62); soft_reset_req = 1'b0;
        step_to(b + 70); pll_locked = 1'b0;
        step_to(b + 71); pll_locked = 1'b1;
        step_to(b + 88); soft_reset_req = 1'b1;
        step_to(b + 89); soft_reset_req = 1'b0;

        // Asynchronous reset while in STABLE, then nominal timing again.
        step_to(b + 96);
        #1;
        expect_at(-1, pk(0, 0, 0, 0, 0));
        resetn = 1'b0;
        pll_locked = 1'b0;
        step_to(b + 99);
        b2 = cyc;
        expect_at(b2 + 3,  pk(0, 0, 0, 0, 0));
        expect_at(b2 + 4,  pk(1, 1, 0, 0, 0));
        expect_at(b2 + 11, pk(1, 1, 0, 0, 0));
        expect_at(b2 + 12, pk(2, 1, 0, 0, 0));
        expect_at(b2 + 19, pk(2, 1, 0, 0, 0));
        expect_at(b2 + 20, pk(3, 1, 1, 0, 0));
        resetn = 1'b1;
        step_to(b2 + 9); pll_locked = 1'b1;

        // Reset in RUN, then lock never arrives: retries exhaust into FAULT, soft reset recovers.
        step_to(b2 + 22);
        #1;
        expect_at(-1, pk(0, 0, 0, 0, 0));
        resetn = 1'b0;
        pll_locked = 1'b0;
        step_to(b2 + 24);
        b3 = cyc;
        expect_at(b3 + 3,  pk(0, 0, 0, 0, 0));
        expect_at(b3 + 4,  pk(1, 1, 0, 0, 0));
        expect_at(b3 + 23, pk(1, 1, 0, 0, 0));
        expect_at(b3 + 24, pk(0, 0, 0, 0, 1));
        expect_at(b3 + 28, pk(1, 1, 0, 0, 1));
        expect_at(b3 + 48, pk(0, 0, 0, 0, 2));
        expect_at(b3 + 52, pk(1, 1, 0, 0, 2));
        expect_at(b3 + 71, pk(1, 1, 0, 0, 2));
        expect_at(b3 + 72, pk(4, 0, 0, 1, 2));
        expect_at(b3 + 80, pk(4, 0, 0, 1, 2));
        expect_at(b3 + 83, pk(0, 0, 0, 0, 0));
        expect_at(b3 + 87, pk(1, 1, 0, 0, 0));
        resetn = 1'b1;
        step_to(b3 + 82); soft_reset_req = 1'b1;
        step_to(b3 + 83); soft_reset_req = 1'b0;
        step_to(b3 + 95);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the iCE40 PLL at power-up and drives the system reset from it.
- Runs on the board reference clock, which is the PLL input. It pulses the PLL's active-low RESETB, waits for LOCK, and requires LOCK to stay high for a set time before releasing system reset.
- On lock timeout or lock loss it retries a bounded number of times, then latches a fault.
- Sits beside the PLL wrapper at the top level. sys_resetn is re-synchronised into the PLL output domain by the consumer; that synchroniser is out of scope.

Parameters:
- PLL_RESET_CYCLES, 16: cycles RESETB is held low per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 100000: cycles allowed in WAIT_LOCK per attempt (1 ms at 100 MHz).
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release (>=1).
- MAX_RETRIES, 3: re-attempts after the first before FAULT (0..15).
- Counter width = clog2 of the largest of PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES.

Ports:
- clock_in, in, 1: reference clock (PLL input clock).
- resetn, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL LOCK; asynchronous to clock_in.
- soft_reset_req, in, 1: single-cycle synchronous request to restart the sequence.
- pll_resetb, out, 1: drives PLL RESETB; 0 = PLL held in reset.
- sys_resetn, out, 1: active-low system reset; 1 only in RUN.
- fault, out, 1: retries exhausted.
- retry_count, out, 4: attempts consumed; saturates at 15.
- state, out, 3: encoding is PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Behaviour:
- Reset (resetn=0, asynchronous): state=PLL_RESET, counter=0, pll_resetb=0, sys_resetn=0, fault=0, retry_count=0, both lock synchroniser flops=0.
- Lock synchroniser: 2 flops. lock_s lags pll_locked by 2 edges.
- Outputs pll_resetb, sys_resetn and fault are registers loaded from next-state, so they change on the same edge as state and never glitch.
  - pll_resetb=0 in PLL_RESET and FAULT; 1 otherwise.
  - sys_resetn=1 only in RUN.
  - fault=1 only in FAULT.
- Counter clears on every state change.
- PLL_RESET: count. When counter == PLL_RESET_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - If lock_s=1, go to STABLE.
  - Else if counter == LOCK_TIMEOUT_CYCLES-1, take the retry path.
- STABLE:
  - If lock_s=0, take the retry path. A flapping lock therefore consumes retries.
  - Else if counter == STABLE_CYCLES-1, go to RUN and clear retry_count.
- Retry path: if retry_count == MAX_RETRIES, go to FAULT; else increment retry_count and go to PLL_RESET.
- RUN: if lock_s=0, go to PLL_RESET with retry_count unchanged. sys_resetn falls on that same edge; latency from the pll_locked fall is 3 edges.
- FAULT: absorbing state; only soft_reset_req or resetn exits it.
- soft_reset_req has highest priority in every state.
  - In FAULT it also clears retry_count; fault deasserts on that edge.
  - In any other state it goes to PLL_RESET with retry_count unchanged, even if PLL_RESET is already active (counter restarts).
- A lock edge that coincides with a timeout edge: lock_s=1 wins (go to STABLE).
- Release latency: pll_locked first sampled high at edge E gives sys_resetn=1 at edge E+2+STABLE_CYCLES, provided lock stays high.

Test Plan (PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2):
1. Nominal start: release resetn, raise pll_locked at cycle 10.
   - pll_resetb is low for cycles 0-3 and high from cycle 4.
   - sys_resetn rises at edge 10+2+8=20; state=3; retry_count=0.
2. Lock never asserts.
   - PLL_RESET entered 3 times; pll_resetb pulses low 3 times.
   - fault=1 at cycle 3×(4+20)=72; retry_count=2; state=4; pll_resetb stays 0.
3. Glitch during STABLE: pll_locked drops for 1 cycle 4 cycles after entering STABLE.
   - Returns to PLL_RESET with retry_count=1.
   - The next clean lock reaches RUN with retry_count=0 and sys_resetn=1.
4. Lock loss in RUN: drop pll_locked at edge F.
   - sys_resetn=0 and pll_resetb=0 at edge F+2 (3-edge latency incl. the sampling edge F).
   - retry_count unchanged; a clean re-lock returns to RUN.
5. Recovery from FAULT: from the end state of scenario 2, pulse soft_reset_req for 1 cycle.
   - Next edge: fault=0, retry_count=0, state=0.
   - Also pulse soft_reset_req in RUN: sys_resetn=0 on the next edge.
6. Mid-sequence reset: assert resetn low asynchronously while in STABLE.
   - All outputs take their reset values immediately, without waiting for a clock edge.
   - After release, scenario 1 timing repeats exactly.
